// File: rtl/traffic_pkg.sv
// Shared light codes, FSM state encoding and per-state light decode for the
// intersection controller and its light datapath.
package traffic_pkg;

  localparam int STATE_W = 4;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_GREEN  = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    ST_NS_GREEN  = 4'd0,
    ST_NS_YELLOW = 4'd1,
    ST_ALLRED_A  = 4'd2,
    ST_EW_GREEN  = 4'd3,
    ST_EW_YELLOW = 4'd4,
    ST_ALLRED_B  = 4'd5,
    ST_WALK      = 4'd6,
    ST_ALLRED_B2 = 4'd7,
    ST_EMG_HOLD  = 4'd8
  } state_e;

  function automatic logic [1:0] ns_code(input state_e s);
    case (s)
      ST_NS_GREEN:  ns_code = LIGHT_GREEN;
      ST_NS_YELLOW: ns_code = LIGHT_YELLOW;
      default:      ns_code = LIGHT_RED;
    endcase
  endfunction

  function automatic logic [1:0] ew_code(input state_e s);
    case (s)
      ST_EW_GREEN:  ew_code = LIGHT_GREEN;
      ST_EW_YELLOW: ew_code = LIGHT_YELLOW;
      default:      ew_code = LIGHT_RED;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Load-on-entry phase down-counter; holds at zero and flags expiry when count==0.
module phase_timer #(
  parameter int                 TIMER_W   = 8,
  parameter logic [TIMER_W-1:0] RESET_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic [TIMER_W-1:0] count,
  output logic               expired
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign expired = (count_q == '0);

endmodule

// File: rtl/intersection_controller.sv
// Two-approach intersection sequencer with latched pedestrian WALK phase.
// Define EMERGENCY_PREEMPT_EN to enable emg_req preemption into EMG_HOLD.
module intersection_controller
  import traffic_pkg::*;
#(
  parameter int GREEN_CYCLES  = 20,
  parameter int YELLOW_CYCLES = 4,
  parameter int ALLRED_CYCLES = 2,
  parameter int WALK_CYCLES   = 10,
  parameter int TIMER_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ped_req,
  input  logic               emg_req,
  output logic [1:0]         ns_light,
  output logic [1:0]         ew_light,
  output logic               walk,
  output logic               ped_pending,
  output logic [STATE_W-1:0] state_dbg
);

  state_e             state_q, state_d;
  logic               ped_q, ped_d;
  logic [1:0]         ns_q, ew_q;
  logic               walk_q;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_load_val;
  logic [TIMER_W-1:0] timer_count;
  logic               timer_expired;

  function automatic logic [TIMER_W-1:0] phase_load(input state_e s);
    case (s)
      ST_NS_GREEN, ST_EW_GREEN:   phase_load = TIMER_W'(GREEN_CYCLES - 1);
      ST_NS_YELLOW, ST_EW_YELLOW: phase_load = TIMER_W'(YELLOW_CYCLES - 1);
      ST_WALK:                    phase_load = TIMER_W'(WALK_CYCLES - 1);
      default:                    phase_load = TIMER_W'(ALLRED_CYCLES - 1);
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NS_GREEN:  if (timer_expired) state_d = ST_NS_YELLOW;
      ST_NS_YELLOW: if (timer_expired) state_d = ST_ALLRED_A;
      ST_ALLRED_A:  if (timer_expired) state_d = ST_EW_GREEN;
      ST_EW_GREEN:  if (timer_expired) state_d = ST_EW_YELLOW;
      ST_EW_YELLOW: if (timer_expired) state_d = ST_ALLRED_B;
      ST_ALLRED_B:  if (timer_expired) state_d = ped_q ? ST_WALK : ST_NS_GREEN;
      ST_WALK:      if (timer_expired) state_d = ST_ALLRED_B2;
      ST_ALLRED_B2: if (timer_expired) state_d = ST_NS_GREEN;
      default:      state_d = ST_ALLRED_B;
    endcase
`ifdef EMERGENCY_PREEMPT_EN
    // Preemption overrides the normal sequence; YELLOW always runs to completion.
    if (emg_req) begin
      case (state_q)
        ST_NS_GREEN:  state_d = ST_NS_YELLOW;
        ST_EW_GREEN:  state_d = ST_EW_YELLOW;
        ST_NS_YELLOW, ST_EW_YELLOW: if (timer_expired) state_d = ST_EMG_HOLD;
        default:      state_d = ST_EMG_HOLD;
      endcase
    end
`endif
  end

  // A request on the WALK-entry cycle is absorbed by that WALK.
  always_comb begin
    ped_d = ped_q;
    if (ped_req && (state_q != ST_WALK)) ped_d = 1'b1;
    if ((state_d == ST_WALK) && (state_q != ST_WALK)) ped_d = 1'b0;
  end

  assign timer_load     = (state_d != state_q);
  assign timer_load_val = phase_load(state_d);

  phase_timer #(
    .TIMER_W   (TIMER_W),
    .RESET_VAL (TIMER_W'(ALLRED_CYCLES - 1))
  ) u_phase_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_load_val),
    .count    (timer_count),
    .expired  (timer_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ALLRED_B;
      ped_q   <= 1'b0;
      ns_q    <= LIGHT_RED;
      ew_q    <= LIGHT_RED;
      walk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ped_q   <= ped_d;
      ns_q    <= ns_code(state_d);
      ew_q    <= ew_code(state_d);
      walk_q  <= (state_d == ST_WALK);
    end
  end

`ifndef EMERGENCY_PREEMPT_EN
  logic unused_emg;
  assign unused_emg = emg_req;
`endif

  logic unused_count;
  assign unused_count = ^timer_count;

  assign ns_light    = ns_q;
  assign ew_light    = ew_q;
  assign walk        = walk_q;
  assign ped_pending = ped_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_intersection_controller.sv
// Table-driven bench for intersection_controller: phase sequence, pedestrian
// latching, async reset abort and emergency preemption.
module tb_intersection_controller;

  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] G = 2'b01;
  localparam logic [1:0] Y = 2'b10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ped_req = 1'b0;
  logic       emg_req = 1'b0;
  logic [1:0] ns_light, ew_light;
  logic       walk, ped_pending;
  logic [3:0] state_dbg;

  int checks = 0;
  int passes = 0;

  typedef struct {
    int         n;
    logic       ped;
    logic       emg;
    logic [1:0] ns;
    logic [1:0] ew;
    logic       walk;
    logic       pend;
  } vec_t;

  vec_t tbl[$];

  intersection_controller dut (
    .clk         (clk),
    .rst         (rst),
    .ped_req     (ped_req),
    .emg_req     (emg_req),
    .ns_light    (ns_light),
    .ew_light    (ew_light),
    .walk        (walk),
    .ped_pending (ped_pending),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    ped_req = 1'b0;
    emg_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic check_val(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Check outputs at the current negedge, then drive inputs for the next posedge.
  task automatic step(input logic p, input logic e, input logic [1:0] ens, input logic [1:0] eew,
                      input logic ewk, input logic epd, input string tag);
    check_val({tag, ".ns"},   ns_light, ens);
    check_val({tag, ".ew"},   ew_light, eew);
    check_val({tag, ".walk"}, {1'b0, walk}, {1'b0, ewk});
    check_val({tag, ".pend"}, {1'b0, ped_pending}, {1'b0, epd});
    ped_req = p;
    emg_req = e;
    @(negedge clk);
  endtask

  task automatic add_row(input int n, input logic p, input logic e, input logic [1:0] ns,
                         input logic [1:0] ew, input logic w, input logic pd);
    vec_t v;
    v.n = n; v.ped = p; v.emg = e; v.ns = ns; v.ew = ew; v.walk = w; v.pend = pd;
    tbl.push_back(v);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      for (int k = 0; k < tbl[i].n; k++)
        step(tbl[i].ped, tbl[i].emg, tbl[i].ns, tbl[i].ew, tbl[i].walk, tbl[i].pend,
             $sformatf("row%0d.%0d", i, k));
  endtask

  // Safety invariants, every cycle out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ((ns_light != R && ew_light != R) || (walk && (ns_light != R || ew_light != R)) ||
          ns_light == 2'b11 || ew_light == 2'b11)
        $display("FAIL safety: ns=%0d ew=%0d walk=%0d (t=%0t)", ns_light, ew_light, walk, $time);
      else passes++;
    end
  end

  initial begin
    // Rows 0-6: free-running period after reset.
    add_row(2, 0,0, R,R, 0,0);  add_row(20,0,0, G,R, 0,0);  add_row(4, 0,0, Y,R, 0,0);
    add_row(2, 0,0, R,R, 0,0);  add_row(20,0,0, R,G, 0,0);  add_row(4, 0,0, R,Y, 0,0);
    add_row(2, 0,0, R,R, 0,0);
    // Rows 7-15: one-cycle pedestrian pulse in NS green, served after EW all-red.
    add_row(1, 1,0, G,R, 0,0);  add_row(19,0,0, G,R, 0,1);  add_row(4, 0,0, Y,R, 0,1);
    add_row(2, 0,0, R,R, 0,1);  add_row(20,0,0, R,G, 0,1);  add_row(4, 0,0, R,Y, 0,1);
    add_row(2, 0,0, R,R, 0,1);  add_row(10,0,0, R,R, 1,0);  add_row(2, 0,0, R,R, 0,0);
    // Rows 16-33: request held across WALK, re-latched after WALK exit.
    add_row(1, 1,0, G,R, 0,0);  add_row(19,1,0, G,R, 0,1);  add_row(4, 1,0, Y,R, 0,1);
    add_row(2, 1,0, R,R, 0,1);  add_row(20,1,0, R,G, 0,1);  add_row(4, 1,0, R,Y, 0,1);
    add_row(2, 1,0, R,R, 0,1);  add_row(10,1,0, R,R, 1,0);  add_row(1, 1,0, R,R, 0,0);
    add_row(1, 0,0, R,R, 0,1);  add_row(20,0,0, G,R, 0,1);  add_row(4, 0,0, Y,R, 0,1);
    add_row(2, 0,0, R,R, 0,1);  add_row(20,0,0, R,G, 0,1);  add_row(4, 0,0, R,Y, 0,1);
    add_row(2, 0,0, R,R, 0,1);  add_row(10,0,0, R,R, 1,0);  add_row(2, 0,0, R,R, 0,0);
    // Rows 34-49: request on the ALLRED_B exit-decision cycle waits a full round.
    add_row(20,0,0, G,R, 0,0);  add_row(4, 0,0, Y,R, 0,0);  add_row(2, 0,0, R,R, 0,0);
    add_row(20,0,0, R,G, 0,0);  add_row(4, 0,0, R,Y, 0,0);  add_row(1, 0,0, R,R, 0,0);
    add_row(1, 1,0, R,R, 0,0);  add_row(20,0,0, G,R, 0,1);  add_row(4, 0,0, Y,R, 0,1);
    add_row(2, 0,0, R,R, 0,1);  add_row(20,0,0, R,G, 0,1);  add_row(4, 0,0, R,Y, 0,1);
    add_row(2, 0,0, R,R, 0,1);  add_row(10,0,0, R,R, 1,0);  add_row(2, 0,0, R,R, 0,0);
    add_row(1, 0,0, G,R, 0,0);

    do_reset();
    run_rows(0, tbl.size() - 1);

    // Asynchronous reset in EW green (cycle 30) with a request pending.
    do_reset();
    step(0,0, R,R, 0,0, "r4.ar0");
    step(0,0, R,R, 0,0, "r4.ar1");
    step(1,0, G,R, 0,0, "r4.g");
    for (int k = 0; k < 19; k++) step(0,0, G,R, 0,1, "r4.ng");
    for (int k = 0; k < 4; k++)  step(0,0, Y,R, 0,1, "r4.ny");
    for (int k = 0; k < 2; k++)  step(0,0, R,R, 0,1, "r4.ara");
    for (int k = 0; k < 2; k++)  step(0,0, R,G, 0,1, "r4.eg");
    #2 rst = 1'b1;
    #1;
    check_val("rst_async.ns",   ns_light, R);
    check_val("rst_async.ew",   ew_light, R);
    check_val("rst_async.walk", {1'b0, walk}, 2'b00);
    check_val("rst_async.pend", {1'b0, ped_pending}, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_rows(0, 6);

    // Emergency request at cycle 5 of NS green, held for 15 cycles.
    for (int k = 0; k < 4; k++) step(0,0, G,R, 0,0, "emg.g");
    step(0,1, G,R, 0,0, "emg.g5");
`ifdef EMERGENCY_PREEMPT_EN
    for (int k = 0; k < 4; k++)  step(0,1, Y,R, 0,0, "emg.y");
    for (int k = 0; k < 10; k++) step(0,1, R,R, 0,0, "emg.hold");
    step(0,0, R,R, 0,0, "emg.hold_last");
    for (int k = 0; k < 2; k++)  step(0,0, R,R, 0,0, "emg.arb");
    step(0,0, G,R, 0,0, "emg.ng");
`else
    for (int k = 0; k < 14; k++) step(0,1, G,R, 0,0, "emg.g_ign");
    step(0,0, G,R, 0,0, "emg.g_last");
    for (int k = 0; k < 4; k++)  step(0,0, Y,R, 0,0, "emg.y");
    for (int k = 0; k < 2; k++)  step(0,0, R,R, 0,0, "emg.ara");
    step(0,0, R,G, 0,0, "emg.eg");
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
